// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit:
// FSM states, opcodes, ALU op codes and datapath select codes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_IF     = 4'd1,
        S_ID     = 4'd2,
        S_BRANCH = 4'd3,
        S_CALC   = 4'd4,
        S_CWRITE = 4'd5,
        S_JUMP   = 4'd6,
        S_STORE  = 4'd7,
        S_LOAD   = 4'd8,
        S_LWRITE = 4'd9,
        S_IMM    = 4'd10,
        S_IWRITE = 4'd11,
        S_TRAP   = 4'd12
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_FUNC = 3'b100
    } alu_op_e;

    localparam logic [3:0] OP_LW    = 4'b0000;
    localparam logic [3:0] OP_SW    = 4'b0001;
    localparam logic [3:0] OP_J     = 4'b0010;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_CTYPE = 4'b1000;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_BUS     = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_TRAP   = 2'b11;

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_ONE = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;

    // Execute state selected in ID; anything unrecognised traps.
    function automatic state_e exec_state(input logic [3:0] opc);
        state_e s;
        s = S_TRAP;
        if (opc[3:2] == 2'b11) s = S_IMM;
        else if (opc == OP_LW) s = S_LOAD;
        else if (opc == OP_SW) s = S_STORE;
        else if (opc == OP_J) s = S_JUMP;
        else if (opc == OP_BEQ) s = S_BRANCH;
        else if (opc == OP_CTYPE) s = S_CALC;
        return s;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_unit_alu_op_decoder.sv
// Maps the FSM's ALU op request to the datapath ALU code;
// C-type instructions take their operation from the func field.
module alu_op_decoder
    import mc_ctrl_pkg::*;
#(
    parameter int FUNC_W  = 9,
    parameter int ALUOP_W = 3
) (
    input  alu_op_e             aluOp,
    input  logic [FUNC_W-1:0]   func,
    output logic [ALUOP_W-1:0]  aluOpc,
    output logic                noOp,
    output logic                moveTo
);

    always_comb begin
        aluOpc = ALUOP_W'(aluOp);
        noOp   = 1'b0;
        moveTo = 1'b0;
        if (aluOp == ALU_FUNC) begin
            // all-zero func is the canonical no-op; top bit flags a move
            aluOpc = func[ALUOP_W-1:0];
            noOp   = ~|func;
            moveTo = func[FUNC_W-1];
        end
    end

endmodule

// File: rtl/multicycle_ctrl_unit.sv
// Multi-cycle CPU control FSM: fetch/decode/execute/writeback
// sequencing with memory wait states, bus timeout and traps.
module multicycle_ctrl_unit
    import mc_ctrl_pkg::*;
#(
    parameter int OPC_W   = 4,
    parameter int FUNC_W  = 9,
    parameter int ALUOP_W = 3,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OPC_W-1:0]   opcode,
    input  logic [FUNC_W-1:0]  func,
    input  logic               memReady,
    output logic               memReq,
    output logic               memRead,
    output logic               memWrite,
    output logic               IorD,
    output logic               IRWrite,
    output logic               regDst,
    output logic               dataFromMem,
    output logic               regWrite,
    output logic               aluSrcA,
    output logic               PcWrite,
    output logic               branch,
    output logic [1:0]         aluSrcB,
    output logic [1:0]         PcSrc,
    output logic [ALUOP_W-1:0] aluOpc,
    output logic               noOp,
    output logic               moveTo,
    output logic               trap,
    output logic [1:0]         trapCause,
    output logic               instRetired
);

    localparam int CNT_W = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cause_q, cause_d;
    alu_op_e          aluOp;
    logic [3:0]       opc4;
    logic             timeout_hit;

    assign opc4      = opcode[3:0];
    assign trapCause = cause_q;
    assign timeout_hit = (TIMEOUT != 0) && memReq && !memReady
                         && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;
        if (memReq && !memReady && cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
        case (state_q)
            S_IDLE: state_d = S_IF;
            S_IF: begin
                if (memReady) state_d = S_ID;
                else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_BUS;
                end
            end
            S_ID: begin
                state_d = exec_state(opc4);
                if (state_d == S_TRAP) cause_d = CAUSE_ILLEGAL;
            end
            S_CALC: state_d = S_CWRITE;
            S_IMM:  state_d = S_IWRITE;
            S_STORE, S_LOAD: begin
                if (memReady)
                    state_d = (state_q == S_LOAD) ? S_LWRITE : S_IF;
                else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_BUS;
                end
            end
            S_BRANCH, S_CWRITE, S_JUMP, S_LWRITE, S_IWRITE, S_TRAP:
                state_d = S_IF;
            default: state_d = S_IDLE;
        endcase
        // each new memory access starts its wait budget afresh
        if (state_d != state_q &&
            (state_d == S_IF || state_d == S_STORE || state_d == S_LOAD))
            cnt_d = '0;
    end

    always_comb begin
        memReq      = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        regDst      = 1'b0;
        dataFromMem = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        PcWrite     = 1'b0;
        branch      = 1'b0;
        aluSrcB     = SRCB_REG;
        PcSrc       = PC_ALU;
        aluOp       = ALU_ADD;
        trap        = 1'b0;
        instRetired = 1'b0;
        case (state_q)
            S_IF: begin
                memReq  = 1'b1;
                memRead = 1'b1;
                aluSrcB = SRCB_ONE;
                IRWrite = memReady;
                PcWrite = memReady;
            end
            S_BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = ALU_SUB;
                branch      = 1'b1;
                PcSrc       = PC_BRANCH;
                instRetired = 1'b1;
            end
            S_CALC: begin
                aluSrcA = 1'b1;
                aluOp   = ALU_FUNC;
            end
            S_CWRITE: begin
                regWrite    = 1'b1;
                aluOp       = ALU_FUNC;
                instRetired = 1'b1;
            end
            S_JUMP: begin
                PcWrite     = 1'b1;
                PcSrc       = PC_JUMP;
                instRetired = 1'b1;
            end
            S_STORE: begin
                memReq      = 1'b1;
                memWrite    = 1'b1;
                IorD        = 1'b1;
                instRetired = memReady;
            end
            S_LOAD: begin
                memReq  = 1'b1;
                memRead = 1'b1;
                IorD    = 1'b1;
            end
            S_LWRITE: begin
                regWrite    = 1'b1;
                regDst      = 1'b1;
                dataFromMem = 1'b1;
                instRetired = 1'b1;
            end
            S_IMM: begin
                aluSrcA = 1'b1;
                aluSrcB = SRCB_IMM;
                aluOp   = alu_op_e'({1'b0, opc4[1:0]});
            end
            S_IWRITE: begin
                regWrite    = 1'b1;
                instRetired = 1'b1;
            end
            S_TRAP: begin
                trap    = 1'b1;
                PcWrite = 1'b1;
                PcSrc   = PC_TRAP;
            end
            default: ;
        endcase
    end

    alu_op_decoder #(
        .FUNC_W  (FUNC_W),
        .ALUOP_W (ALUOP_W)
    ) u_alu_dec (
        .aluOp  (aluOp),
        .func   (func),
        .aluOpc (aluOpc),
        .noOp   (noOp),
        .moveTo (moveTo)
    );

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Scoreboard bench for multicycle_ctrl_unit: directed instruction
// sequences push expected outputs, a negedge monitor compares them.
module tb_multicycle_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic [8:0] func;
    logic       memReady;
    logic       memReq, memRead, memWrite, IorD, IRWrite, regDst;
    logic       dataFromMem, regWrite, aluSrcA, PcWrite, branch;
    logic [1:0] aluSrcB, PcSrc, trapCause;
    logic [2:0] aluOpc;
    logic       noOp, moveTo, trap, instRetired;

    typedef struct packed {
        logic       memReq, memRead, memWrite, IorD, IRWrite, regDst;
        logic       dataFromMem, regWrite, aluSrcA, PcWrite, branch;
        logic [1:0] aluSrcB;
        logic [1:0] PcSrc;
        logic [2:0] aluOpc;
        logic       noOp, moveTo, trap;
        logic [1:0] trapCause;
        logic       instRetired;
    } exp_t;

    exp_t       sb[$];
    string      nm[$];
    int         errors = 0;
    int         checks = 0;
    logic [1:0] cause = 2'b00;

    always #5 clk = ~clk;

    multicycle_ctrl_unit #(
        .OPC_W(4), .FUNC_W(9), .ALUOP_W(3), .TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func),
        .memReady(memReady), .memReq(memReq), .memRead(memRead),
        .memWrite(memWrite), .IorD(IorD), .IRWrite(IRWrite),
        .regDst(regDst), .dataFromMem(dataFromMem),
        .regWrite(regWrite), .aluSrcA(aluSrcA), .PcWrite(PcWrite),
        .branch(branch), .aluSrcB(aluSrcB), .PcSrc(PcSrc),
        .aluOpc(aluOpc), .noOp(noOp), .moveTo(moveTo), .trap(trap),
        .trapCause(trapCause), .instRetired(instRetired)
    );

    function automatic exp_t base();
        exp_t e;
        e = '0;
        e.trapCause = cause;
        return e;
    endfunction

    function automatic exp_t x_zero();
        exp_t e;
        e = '0;
        return e;
    endfunction

    function automatic exp_t x_if(input logic rdy);
        exp_t e = base();
        e.memReq = 1; e.memRead = 1; e.aluSrcB = 2'b01;
        e.IRWrite = rdy; e.PcWrite = rdy;
        return e;
    endfunction

    function automatic exp_t x_imm(input logic [2:0] opc);
        exp_t e = base();
        e.aluSrcA = 1; e.aluSrcB = 2'b10; e.aluOpc = opc;
        return e;
    endfunction

    function automatic exp_t x_iw();
        exp_t e = base();
        e.regWrite = 1; e.instRetired = 1;
        return e;
    endfunction

    function automatic exp_t x_calc(input logic wr, input logic [2:0] opc,
                                    input logic nop, input logic mv);
        exp_t e = base();
        e.aluSrcA = !wr; e.regWrite = wr; e.instRetired = wr;
        e.aluOpc = opc; e.noOp = nop; e.moveTo = mv;
        return e;
    endfunction

    function automatic exp_t x_mem(input logic wr, input logic ret);
        exp_t e = base();
        e.memReq = 1; e.IorD = 1;
        e.memWrite = wr; e.memRead = !wr; e.instRetired = ret;
        return e;
    endfunction

    function automatic exp_t x_lw();
        exp_t e = base();
        e.regWrite = 1; e.regDst = 1; e.dataFromMem = 1;
        e.instRetired = 1;
        return e;
    endfunction

    function automatic exp_t x_br();
        exp_t e = base();
        e.aluSrcA = 1; e.aluOpc = 3'b001; e.branch = 1;
        e.PcSrc = 2'b01; e.instRetired = 1;
        return e;
    endfunction

    function automatic exp_t x_jmp();
        exp_t e = base();
        e.PcWrite = 1; e.PcSrc = 2'b10; e.instRetired = 1;
        return e;
    endfunction

    function automatic exp_t x_trap();
        exp_t e = base();
        e.trap = 1; e.PcWrite = 1; e.PcSrc = 2'b11;
        return e;
    endfunction

    task automatic cyc(input string n, input exp_t e);
        sb.push_back(e);
        nm.push_back(n);
        @(posedge clk);
        #1;
    endtask

    // fetch with memReady high, then decode
    task automatic fetch(input logic [3:0] op);
        opcode = op;
        memReady = 1'b1;
        cyc("if", x_if(1'b1));
        cyc("id", base());
    endtask

    initial begin
        exp_t  e, a;
        string n;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n = nm.pop_front();
                a = {memReq, memRead, memWrite, IorD, IRWrite, regDst,
                     dataFromMem, regWrite, aluSrcA, PcWrite, branch,
                     aluSrcB, PcSrc, aluOpc, noOp, moveTo, trap,
                     trapCause, instRetired};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s: got %h want %h", n, a, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; opcode = 4'b0; func = 9'b0; memReady = 1'b0;
        @(posedge clk);
        #1;
        cyc("reset", x_zero());
        rst = 1'b1;
        cyc("idle", x_zero());

        // immediate add
        fetch(4'b1100);
        cyc("imm_add", x_imm(3'b000));
        cyc("iwrite", x_iw());

        // fetch with three wait states, then C-type
        opcode = 4'b1000;
        func = 9'h105;
        memReady = 1'b0;
        for (int i = 0; i < 3; i++) cyc("if_wait", x_if(1'b0));
        memReady = 1'b1;
        cyc("if_done", x_if(1'b1));
        cyc("id", base());
        cyc("calc", x_calc(1'b0, 3'b101, 1'b0, 1'b1));
        cyc("cwrite", x_calc(1'b1, 3'b101, 1'b0, 1'b1));

        // C-type no-op func
        func = 9'h000;
        fetch(4'b1000);
        cyc("calc_nop", x_calc(1'b0, 3'b000, 1'b1, 1'b0));
        cyc("cwrite_nop", x_calc(1'b1, 3'b000, 1'b1, 1'b0));

        // load stalls until bus timeout
        fetch(4'b0000);
        memReady = 1'b0;
        for (int i = 0; i < 4; i++) cyc("ld_wait", x_mem(1'b0, 1'b0));
        cause = 2'b10;
        cyc("trap_bus", x_trap());

        // illegal opcode
        fetch(4'b0101);
        cause = 2'b01;
        cyc("trap_ill", x_trap());

        // store completes on the timeout cycle
        fetch(4'b0001);
        memReady = 1'b0;
        for (int i = 0; i < 3; i++) cyc("st_wait", x_mem(1'b1, 1'b0));
        memReady = 1'b1;
        cyc("st_done", x_mem(1'b1, 1'b1));

        // branch and jump
        fetch(4'b0100);
        cyc("branch", x_br());
        fetch(4'b0010);
        cyc("jump", x_jmp());

        // load with one wait state
        fetch(4'b0000);
        memReady = 1'b0;
        cyc("ld_wait1", x_mem(1'b0, 1'b0));
        memReady = 1'b1;
        cyc("ld_done", x_mem(1'b0, 1'b0));
        cyc("lwrite", x_lw());

        // immediate sub / and
        fetch(4'b1101);
        cyc("imm_sub", x_imm(3'b001));
        cyc("iwrite", x_iw());
        fetch(4'b1110);
        cyc("imm_and", x_imm(3'b010));
        cyc("iwrite", x_iw());

        // reset in the middle of a load wait
        fetch(4'b0000);
        memReady = 1'b0;
        cyc("ld_wait", x_mem(1'b0, 1'b0));
        rst = 1'b0;
        cause = 2'b00;
        cyc("rst_mid", x_zero());
        cyc("rst_hold", x_zero());
        rst = 1'b1;
        cyc("idle2", x_zero());
        fetch(4'b1111);
        cyc("imm_or", x_imm(3'b011));
        cyc("iwrite", x_iw());

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
